piso_shift_tx: RTL and testbench

Parallel-in, serial-out shift transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per enable strobe on a single serial line, with frame qualifiers and a completion pulse. It is the transmit end of the team's flip-flop-based serial-in/parallel-out capture chain, and sits between a parallel data source and any bit-serial link driven by a shared bit-rate tick.

---
 rtl/piso_shift_tx.sv | 100 ++++++++++
 tb/tb_piso_shift_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_tx.sv
`default_nettype none
// ============================================================================
//  Module      : piso_shift_tx
//  Description : Parallel-in, serial-out shift transmitter with valid/ready
//                word intake, bit_tick-paced serial output and done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             bit_tick,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int             C_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_sreg,  w_sreg_nxt;
    logic [C_CW-1:0]    r_cnt,   w_cnt_nxt;
    logic               r_done,  w_done_nxt;
    logic               w_out_bit;
    logic [WIDTH-1:0]   w_shifted;

    // Output end of the shift register and the one-step shift toward it.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_out_bit = r_sreg[0];
            assign w_shifted = {1'b0, r_sreg[WIDTH-1:1]};
        end else begin : g_msb_first
            assign w_out_bit = r_sreg[WIDTH-1];
            assign w_shifted = {r_sreg[WIDTH-2:0], 1'b0};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sreg  <= w_sreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                // A tick coinciding with accept is dropped so bit 0 is held a full period.
                if (in_valid) begin
                    w_sreg_nxt  = in_data;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_tick) begin
                    if (r_cnt == C_LAST) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_sreg_nxt = w_shifted;
                        w_cnt_nxt  = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign in_ready    = (r_state == IDLE);
    assign ser_valid   = (r_state == SHIFT);
    assign ser_out     = ser_valid & w_out_bit;
    assign frame_start = ser_valid & (r_cnt == '0);
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_piso_shift_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_shift_tx
//  Description : Directed, table-driven bench for piso_shift_tx (MSB-first and
//                LSB-first instances, WIDTH = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_shift_tx;

    logic       clk;
    logic       rst;
    logic       a_valid, a_ready, a_tick, a_ser, a_sv, a_fs, a_done;
    logic [7:0] a_data;
    logic       b_valid, b_ready, b_tick, b_ser, b_sv, b_fs, b_done;
    logic [7:0] b_data;

    int checks   = 0;
    int failures = 0;

    piso_shift_tx #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready),
        .in_data(a_data), .bit_tick(a_tick), .ser_out(a_ser),
        .ser_valid(a_sv), .frame_start(a_fs), .done(a_done)
    );

    piso_shift_tx #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .bit_tick(b_tick), .ser_out(b_ser),
        .ser_valid(b_sv), .frame_start(b_fs), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // Inputs applied to the MSB instance for one edge, and the outputs
    // {in_ready, ser_out, ser_valid, frame_start, done} expected after it.
    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       t;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic v, input logic [7:0] d,
                                input logic t, input logic [4:0] exp);
        vec_t r;
        r.v = v; r.d = d; r.t = t; r.exp = exp;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [4:0] a_outs();
        return {a_ready, a_ser, a_sv, a_fs, a_done};
    endfunction

    function automatic logic [4:0] b_outs();
        return {b_ready, b_ser, b_sv, b_fs, b_done};
    endfunction

    // Sends d on the MSB instance with a continuous tick and checks every bit.
    task automatic frame_msb(input logic [7:0] d, input string tag);
        a_valid = 1'b1; a_data = d; a_tick = 1'b1;
        step();
        a_valid = 1'b0; a_data = 8'h00;
        check({tag, "_first"}, a_outs(), {1'b0, d[7], 1'b1, 1'b1, 1'b0});
        for (int i = 1; i < 8; i++) begin
            step();
            check($sformatf("%s_bit%0d", tag, i), a_outs(),
                  {1'b0, d[7-i], 1'b1, 1'b0, 1'b0});
        end
        step();
        check({tag, "_done"}, a_outs(), 5'b10001);
        step();
        check({tag, "_idle"}, a_outs(), 5'b10000);
    endtask

    initial begin
        logic [7:0] pat;

        rst = 1'b0;
        a_valid = 1'b0; a_data = 8'h00; a_tick = 1'b0;
        b_valid = 1'b0; b_data = 8'h00; b_tick = 1'b0;

        // Reset held: activity on inputs must not move any output.
        for (int i = 0; i < 4; i++) begin
            a_valid = i[0]; a_data = 8'hFF; a_tick = i[1];
            b_valid = i[0]; b_data = 8'h5A; b_tick = ~i[1];
            step();
            check("reset_a", a_outs(), 5'b10000);
            check("reset_b", b_outs(), 5'b10000);
        end
        a_valid = 1'b0; a_tick = 1'b0; b_valid = 1'b0; b_tick = 1'b0;
        #1 rst = 1'b1;
        step();
        check("post_reset_a", a_outs(), 5'b10000);

        // MSB-first 8'hA5, tick always high (including the accept cycle).
        vecs.push_back(mk(1'b1, 8'hA5, 1'b1, 5'b01110));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 5'b00100));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 5'b01100));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 5'b00100));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 5'b00100));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 5'b01100));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 5'b00100));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 5'b01100));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 5'b10001));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 5'b10000));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 5'b10000));
        for (int i = 0; i < vecs.size(); i++) begin
            a_valid = vecs[i].v; a_data = vecs[i].d; a_tick = vecs[i].t;
            step();
            check($sformatf("vec%0d", i), a_outs(), vecs[i].exp);
        end
        a_tick = 1'b0;

        // LSB-first 8'hA5, tick every third cycle, 8'hFF offered mid-frame.
        pat = 8'hA5;
        b_valid = 1'b1; b_data = pat; b_tick = 1'b1;
        step();
        b_valid = 1'b0; b_data = 8'h00;
        check("lsb_first", b_outs(), {1'b0, pat[0], 1'b1, 1'b1, 1'b0});
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < 2; c++) begin
                b_tick = 1'b0;
                b_valid = (i == 3 && c == 1);
                b_data  = (i == 3 && c == 1) ? 8'hFF : 8'h00;
                step();
                check($sformatf("lsb_hold%0d_%0d", i, c), b_outs(),
                      {1'b0, pat[i], 1'b1, (i == 0), 1'b0});
            end
            b_valid = 1'b0; b_data = 8'h00; b_tick = 1'b1;
            step();
            if (i < 7)
                check($sformatf("lsb_bit%0d", i + 1), b_outs(),
                      {1'b0, pat[i+1], 1'b1, 1'b0, 1'b0});
            else
                check("lsb_done", b_outs(), 5'b10001);
        end
        b_tick = 1'b0;
        step();
        check("lsb_idle", b_outs(), 5'b10000);

        // Back-to-back: in_valid held high, 8'h01 then 8'h80.
        a_valid = 1'b1; a_data = 8'h01; a_tick = 1'b1;
        step();
        a_data = 8'h80;
        check("b2b_f1_first", a_outs(), 5'b00110);
        for (int i = 1; i < 8; i++) begin
            step();
            check($sformatf("b2b_f1_bit%0d", i), a_outs(),
                  {1'b0, (i == 7), 1'b1, 1'b0, 1'b0});
        end
        step();
        check("b2b_gap", a_outs(), 5'b10001);
        step();
        a_valid = 1'b0;
        check("b2b_f2_first", a_outs(), 5'b01110);
        for (int i = 1; i < 8; i++) begin
            step();
            check($sformatf("b2b_f2_bit%0d", i), a_outs(), 5'b00100);
        end
        step();
        check("b2b_f2_done", a_outs(), 5'b10001);
        step();
        a_tick = 1'b0;

        // Reset mid-frame after bit 3 of 8'h3C, then 8'hC3 must go out cleanly.
        a_valid = 1'b1; a_data = 8'h3C; a_tick = 1'b1;
        step();
        a_valid = 1'b0;
        for (int i = 1; i < 4; i++) step();
        check("mid_bit3", a_outs(), 5'b01100);
        rst = 1'b0;
        #1;
        check("mid_async_reset", a_outs(), 5'b10000);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_reset_hold", a_outs(), 5'b10000);
        end
        rst = 1'b1;
        step();
        check("mid_no_done", a_outs(), 5'b10000);
        frame_msb(8'hC3, "recover");

        // Tick only in the accept cycle, then sparse: the accept-cycle tick is dropped.
        a_valid = 1'b1; a_data = 8'h80; a_tick = 1'b1;
        step();
        a_valid = 1'b0; a_tick = 1'b0;
        step();
        check("collide_hold", a_outs(), 5'b01110);
        for (int i = 0; i < 8; i++) begin
            a_tick = 1'b1;
            step();
            a_tick = 1'b0;
            if (i < 7)
                check($sformatf("collide_bit%0d", i + 1), a_outs(), 5'b00100);
            else
                check("collide_done", a_outs(), 5'b10001);
        end
        step();
        check("collide_idle", a_outs(), 5'b10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
